// File: rtl/hex_seg_pkg.sv
// Shared 7-segment bit indices, glyph constants and chase-mode type.
package hex_seg_pkg;

    localparam int unsigned SEG_W  = 8;
    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_B  = 1;
    localparam int unsigned SEG_C  = 2;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_E  = 4;
    localparam int unsigned SEG_F  = 5;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    // Active-high glyphs; dp is always off
    localparam logic [SEG_W-1:0] HIGH_CIRCLE = 8'b0110_0011; // a,b,f,g
    localparam logic [SEG_W-1:0] LOW_CIRCLE  = 8'b0101_1100; // c,d,e,g
    localparam logic [SEG_W-1:0] OFF         = 8'b0000_0000;

    typedef enum logic {
        MODE_CIRCLE = 1'b0,
        MODE_PERIM  = 1'b1
    } chase_mode_e;

endpackage

// File: rtl/hex_circle_chaser_tick_prescaler.sv
// Free-running divider: one tick every DIV enabled cycles, frozen while disabled.
module tick_prescaler #(
    parameter int unsigned DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Tick is combinational so the owner can act on it in the same cycle (DIV = 1 ticks every cycle)
    always_comb begin
        cnt_d  = cnt_q;
        tick_o = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                tick_o = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/hex_circle_chaser.sv
// Steps a circle or perimeter-chase pattern across a row of 7-segment digits.
module hex_circle_chaser
    import hex_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 6,
    parameter bit          COMMON_ANODE = 1'b1,
    parameter int unsigned TICK_DIV     = 5_000_000
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                en_i,
    input  logic                                step_i,
    input  logic                                dir_i,
    input  logic                                mode_i,
    input  logic                                blank_i,
    output logic [8*NUM_DIGITS-1:0]             seg7_o,
    output logic [$clog2(2*NUM_DIGITS+4)-1:0]   pos_o,
    output logic                                wrap_o
);

    localparam int unsigned   N           = NUM_DIGITS;
    localparam int unsigned   BW          = SEG_W * N;
    localparam int unsigned   IW          = $clog2(BW);
    localparam int unsigned   PW          = $clog2(2 * N + 4);
    localparam logic [PW-1:0] LAST_CIRCLE = PW'(2 * N - 1);
    localparam logic [PW-1:0] LAST_PERIM  = PW'(2 * N + 3);
    localparam logic [BW-1:0] POL_MASK    = {BW{COMMON_ANODE}};

    // Position/mode -> active-high segment bus; unlit digits stay OFF
    function automatic logic [BW-1:0] decode_pattern(input logic [PW-1:0] pos,
                                                     input chase_mode_e   mode);
        logic [BW-1:0] bus;
        logic [IW-1:0] idx;
        int unsigned   p;
        bus = {N{OFF}};
        idx = '0;
        p   = 32'(pos);
        if (mode == MODE_CIRCLE) begin
            if (p < N) begin
                idx = IW'(SEG_W * (N - 1 - p));
                bus[idx +: SEG_W] = HIGH_CIRCLE;
            end else if (p < 2 * N) begin
                idx = IW'(SEG_W * (p - N));
                bus[idx +: SEG_W] = LOW_CIRCLE;
            end
        end else begin
            if (p < N) begin
                idx = IW'(SEG_W * (N - 1 - p) + SEG_A);
                bus[idx] = 1'b1;
            end else if (p == N) begin
                bus[SEG_B] = 1'b1;
            end else if (p == N + 1) begin
                bus[SEG_C] = 1'b1;
            end else if (p < 2 * N + 2) begin
                idx = IW'(SEG_W * (p - N - 2) + SEG_D);
                bus[idx] = 1'b1;
            end else if (p == 2 * N + 2) begin
                idx = IW'(SEG_W * (N - 1) + SEG_E);
                bus[idx] = 1'b1;
            end else if (p == 2 * N + 3) begin
                idx = IW'(SEG_W * (N - 1) + SEG_F);
                bus[idx] = 1'b1;
            end
        end
        return bus;
    endfunction

    chase_mode_e   mode_in;
    chase_mode_e   mode_q;
    chase_mode_e   mode_d;
    logic [PW-1:0] pos_q;
    logic [PW-1:0] pos_d;
    logic [PW-1:0] last_pos;
    logic          wrap_q;
    logic          wrap_d;
    logic [BW-1:0] seg_q;
    logic [BW-1:0] seg_d;
    logic          mode_chg;
    logic          tick;
    logic          advance;

    assign mode_in  = chase_mode_e'(mode_i);
    assign mode_chg = (mode_in != mode_q);
    assign last_pos = (mode_q == MODE_PERIM) ? LAST_PERIM : LAST_CIRCLE;
    assign advance  = en_i ? tick : step_i;

    // Rate divider; a mode change restarts the step interval
    tick_prescaler #(
        .DIV    (TICK_DIV)
    ) u_prescaler (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (en_i),
        .clr_i  (mode_chg),
        .tick_o (tick)
    );

    // State registers; seg reset value is "all off" in the configured polarity
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_q <= MODE_CIRCLE;
            pos_q  <= '0;
            wrap_q <= 1'b0;
            seg_q  <= POL_MASK;
        end else begin
            mode_q <= mode_d;
            pos_q  <= pos_d;
            wrap_q <= wrap_d;
            seg_q  <= seg_d;
        end
    end

    // Next position (mode change outranks advance) and next segment bus
    always_comb begin
        mode_d = mode_q;
        pos_d  = pos_q;
        wrap_d = 1'b0;
        seg_d  = '0;
        if (mode_chg) begin
            mode_d = mode_in;
            pos_d  = '0;
        end else if (advance) begin
            if (!dir_i) begin
                if (pos_q == last_pos) begin
                    pos_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    pos_d = pos_q + PW'(1);
                end
            end else begin
                if (pos_q == '0) begin
                    pos_d  = last_pos;
                    wrap_d = 1'b1;
                end else begin
                    pos_d = pos_q - PW'(1);
                end
            end
        end
        seg_d = blank_i ? {N{OFF}} : decode_pattern(pos_q, mode_q);
        seg_d = seg_d ^ POL_MASK;
    end

    assign seg7_o = seg_q;
    assign pos_o  = pos_q;
    assign wrap_o = wrap_q;

endmodule

// File: tb/tb_hex_circle_chaser.sv
// Scoreboard bench for hex_circle_chaser (N=6, common anode, TICK_DIV=4).
module tb_hex_circle_chaser;

    localparam logic [47:0] ALL_OFF = 48'hFFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        step = 1'b0;
    logic        dir = 1'b0;
    logic        mode = 1'b0;
    logic        blank = 1'b0;
    logic [47:0] seg7;
    logic [3:0]  pos;
    logic        wrap;

    hex_circle_chaser #(
        .NUM_DIGITS   (6),
        .COMMON_ANODE (1'b1),
        .TICK_DIV     (4)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .en_i    (en),
        .step_i  (step),
        .dir_i   (dir),
        .mode_i  (mode),
        .blank_i (blank),
        .seg7_o  (seg7),
        .pos_o   (pos),
        .wrap_o  (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          chk_pos;
        logic [3:0]  pos;
        bit          chk_seg;
        logic [47:0] seg;
        bit          chk_wrap;
        logic        wrap;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   k = 0;
    bit   done = 1'b0;

    task automatic push(input string nm, input bit cp, input int p, input bit cs,
                        input logic [47:0] s, input bit cw, input bit w);
        exp_t e;
        e.name = nm; e.chk_pos = cp; e.pos = 4'(p);
        e.chk_seg = cs; e.seg = s; e.chk_wrap = cw; e.wrap = w;
        q.push_back(e);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic run_to(input int t);
        while (k < t) adv();
    endtask

    // Monitor: outputs are sampled at every falling edge; one expectation consumed per sample
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.chk_pos) begin
                    checks++;
                    if (pos !== e.pos) begin
                        errors++;
                        $display("FAIL %s pos: got %0d expected %0d (t=%0t)", e.name, pos, e.pos, $time);
                    end
                end
                if (e.chk_seg) begin
                    checks++;
                    if (seg7 !== e.seg) begin
                        errors++;
                        $display("FAIL %s seg7: got %h expected %h (t=%0t)", e.name, seg7, e.seg, $time);
                    end
                end
                if (e.chk_wrap) begin
                    checks++;
                    if (wrap !== e.wrap) begin
                        errors++;
                        $display("FAIL %s wrap: got %b expected %b (t=%0t)", e.name, wrap, e.wrap, $time);
                    end
                end
            end
        end
    end

    // Directed stimulus; k counts rising edges after the first post-reset pattern load
    initial begin
        adv();
        push("reset_hold", 1, 0, 1, ALL_OFF, 1, 0);
        @(negedge clk);
        #1;
        rst = 1'b0;

        adv();
        k = 0;
        push("first_pattern", 1, 0, 1, 48'h9CFF_FFFF_FFFF, 1, 0);
        en = 1'b1;

        // Circle forward: tick every 4th edge, wrap 11 -> 0 at k=48
        for (int i = 1; i <= 48; i++) begin
            adv();
            push("circ_fwd", 1, (i / 4) % 12, (i == 25), 48'hFFFF_FFFF_FFA3, 1, (i == 48));
        end

        // Reverse from 0 wraps to 11
        dir = 1'b1;
        for (int i = 0; i < 3; i++) begin
            adv();
            push("rev_hold", 1, 0, 0, '0, 1, 0);
        end
        adv(); push("rev_wrap", 1, 11, 0, '0, 1, 1);
        adv(); push("rev_hex5", 1, 11, 1, 48'hA3FF_FFFF_FFFF, 1, 0);
        run_to(78);
        adv(); push("pos5_pre_mode", 1, 5, 0, '0, 1, 0);

        // Mode switch lands on a tick edge: restart at 0 without wrap
        mode = 1'b1;
        dir  = 1'b0;
        adv(); push("mode_chg", 1, 0, 0, '0, 1, 0);
        adv(); push("perim_p0", 1, 0, 1, 48'hFEFF_FFFF_FFFF, 1, 0);
        run_to(103);
        adv(); push("perim_pos6", 1, 6, 0, '0, 1, 0);
        adv(); push("perim_b0", 1, 6, 1, 48'hFFFF_FFFF_FFFD, 0, 0);
        run_to(112);
        adv(); push("perim_d0", 1, 8, 1, 48'hFFFF_FFFF_FFF7, 0, 0);
        run_to(136);
        adv(); push("perim_e5", 1, 14, 1, 48'hEFFF_FFFF_FFFF, 0, 0);
        run_to(140);
        adv(); push("perim_f5", 1, 15, 1, 48'hDFFF_FFFF_FFFF, 1, 0);
        run_to(143);
        adv(); push("perim_wrap", 1, 0, 0, '0, 1, 1);
        adv(); push("perim_wrap_end", 1, 0, 1, 48'hFEFF_FFFF_FFFF, 1, 0);

        // Paused: three single steps, prescaler frozen at 1
        en = 1'b0;
        adv(); push("paused", 1, 0, 0, '0, 1, 0);
        step = 1'b1;
        adv(); push("step1", 1, 1, 0, '0, 1, 0);
        step = 1'b0;
        adv(); push("step_gap", 1, 1, 0, '0, 0, 0);
        step = 1'b1;
        adv(); push("step2", 1, 2, 0, '0, 0, 0);
        step = 1'b0;
        adv(); push("step_gap2", 1, 2, 0, '0, 0, 0);
        step = 1'b1;
        adv(); push("step3", 1, 3, 0, '0, 1, 0);
        step = 1'b0;
        adv(); push("step_done", 1, 3, 0, '0, 0, 0);

        // Running again: step ignored, frozen count resumes (tick on 3rd edge)
        en   = 1'b1;
        step = 1'b1;
        adv(); push("step_ignored", 1, 3, 0, '0, 0, 0);
        adv(); push("step_ignored2", 1, 3, 0, '0, 0, 0);
        step = 1'b0;
        adv(); push("presc_frozen", 1, 4, 1, 48'hFFFF_FFFE_FFFF, 0, 0);
        blank = 1'b1;
        adv(); push("blank", 1, 4, 1, ALL_OFF, 0, 0);
        blank = 1'b0;
        adv(); push("unblank", 1, 4, 1, 48'hFFFF_FFFF_FEFF, 0, 0);

        // Asynchronous reset between edges
        @(posedge clk);
        #2;
        rst = 1'b1;
        push("async_rst", 1, 0, 1, ALL_OFF, 1, 0);
        adv();
        adv();
        rst = 1'b0;
        done = 1'b1;
    end

    // Drain the scoreboard with a bounded wait, then report
    initial begin
        int budget;
        wait (done);
        budget = 20;
        while (q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: timeout at %0t, required completion", $time);
        $fatal(1, "timeout");
    end

endmodule
